// File: rtl/note_matcher.sv
// note_matcher: row-serial matcher scoring a 16x16 one-bit window against the seven note templates A..G
// Optional feature: define MATCH_EARLY_EXIT_EN to finish as soon as a note scores a perfect 256.
module note_matcher #(
    parameter logic [8:0] MIN_SCORE = 9'd192
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] window,
    input  logic [255:0] tinymap,
    output logic [2:0]   sel,
    output logic         busy,
    output logic         done,
    output logic [2:0]   best_note,
    output logic [8:0]   best_score,
    output logic         match
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]   r_state;
    logic [255:0] r_win;
    logic [3:0]   r_row;
    logic [8:0]   r_acc;
    logic [8:0]   r_best;
    logic [2:0]   r_best_idx;
    logic [2:0]   r_sel;
    logic         r_done;
    logic [2:0]   r_best_note;
    logic [8:0]   r_best_score;
    logic         r_match;

    logic [7:0]   w_lo;
    logic [15:0]  w_agree;
    logic [4:0]   w_pc;
    logic [8:0]   w_score;
    logic         w_better;
    logic [8:0]   w_new_best;
    logic [2:0]   w_new_idx;
    logic         w_last;

    // Row 0 lives in the top 16 bits, so row r starts at bit (15-r)*16.
    assign w_lo       = {~r_row, 4'd0};
    assign w_agree    = ~(tinymap[w_lo +: 16] ^ r_win[w_lo +: 16]);
    assign w_score    = r_acc + {4'd0, w_pc};
    assign w_better   = w_score > r_best;
    assign w_new_best = w_better ? w_score : r_best;
    assign w_new_idx  = w_better ? r_sel : r_best_idx;
`ifdef MATCH_EARLY_EXIT_EN
    assign w_last     = (r_sel == 3'd6) || (w_score == 9'd256);
`else
    assign w_last     = r_sel == 3'd6;
`endif

    assign sel        = r_sel;
    assign busy       = r_state == SCAN;
    assign done       = r_done;
    assign best_note  = r_best_note;
    assign best_score = r_best_score;
    assign match      = r_match;

    // Count agreeing pixels in the current row.
    always_comb begin
        w_pc = 5'd0;
        for (int i = 0; i < 16; i++) w_pc = w_pc + {4'd0, w_agree[i]};
    end

    // Control FSM: capture window, scan 16 rows per note, publish the best note.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_win        <= '0;
            r_row        <= '0;
            r_acc        <= '0;
            r_best       <= '0;
            r_best_idx   <= '0;
            r_sel        <= '0;
            r_done       <= 1'b0;
            r_best_note  <= '0;
            r_best_score <= '0;
            r_match      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_win      <= window;
                    r_sel      <= '0;
                    r_row      <= '0;
                    r_acc      <= '0;
                    r_best     <= '0;
                    r_best_idx <= '0;
                    r_state    <= SCAN;
                end
                SCAN: if (r_row != 4'd15) begin
                    r_row <= r_row + 4'd1;
                    r_acc <= w_score;
                end else begin
                    r_best     <= w_new_best;
                    r_best_idx <= w_new_idx;
                    r_row      <= '0;
                    r_acc      <= '0;
                    if (w_last) begin
                        r_state      <= DONE;
                        r_done       <= 1'b1;
                        r_best_note  <= w_new_idx;
                        r_best_score <= w_new_best;
                        r_match      <= w_new_best >= MIN_SCORE;
                    end else begin
                        r_sel <= r_sel + 3'd1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_note_matcher.sv
// tb_note_matcher: randomized self-checking bench for note_matcher with a whole-window scoring model
module tb_note_matcher;
    localparam logic [8:0] MINS = 9'd256;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [255:0] window = '0;
    logic [255:0] tinymap;
    logic [2:0]   sel;
    logic         busy;
    logic         done;
    logic [2:0]   best_note;
    logic [8:0]   best_score;
    logic         match;

    logic [255:0] tmpl [8];
    int errors = 0;
    int checks = 0;
    logic [2:0] prev_note = '0;
    logic [8:0] prev_score = '0;
    logic       prev_match = 1'b0;

    always #5 clk = ~clk;

    // Note template mux model.
    assign tinymap = tmpl[sel];

    note_matcher #(.MIN_SCORE(MINS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .window(window), .tinymap(tinymap),
        .sel(sel), .busy(busy), .done(done), .best_note(best_note),
        .best_score(best_score), .match(match)
    );

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Whole-window scoring: agreements = 256 - ones(w ^ t), strict > keeps lowest index.
    task automatic model(input logic [255:0] w, output logic [2:0] n, output logic [8:0] s,
                         output logic m, output int cyc);
        int best;
        int sc;
        best = 0;
        n = 3'd0;
        cyc = 113;
        for (int k = 0; k < 7; k++) begin
            sc = 256 - $countones(w ^ tmpl[k]);
            if (sc > best) begin
                best = sc;
                n = 3'(k);
            end
`ifdef MATCH_EARLY_EXIT_EN
            if (sc == 256 && cyc == 113) cyc = 16 * (k + 1) + 1;
`endif
        end
        s = 9'(best);
        m = best >= int'(MINS);
    endtask

    task automatic run(input logic [255:0] w, input int s1, input int s2, input int tail, input string nm);
        logic [2:0] en;
        logic [8:0] es;
        logic       em;
        int         ec;
        logic [2:0] esel;
        model(w, en, es, em, ec);
        @(negedge clk);
        window = w;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        window = ~w;
        for (int c = 1; c <= ec + tail; c++) begin
            start = (c == s1) || (c == s2);
            checks++;
            if (done !== (c == ec)) begin
                errors++;
                $display("FAIL %s done cycle %0d: got %b want %b", nm, c, done, c == ec);
            end
            checks++;
            if (busy !== (c < ec)) begin
                errors++;
                $display("FAIL %s busy cycle %0d: got %b want %b", nm, c, busy, c < ec);
            end
            esel = (c < ec) ? 3'((c - 1) / 16) : 3'((ec - 1) / 16 - 1);
            if (c <= ec) begin
                checks++;
                if (sel !== esel) begin
                    errors++;
                    $display("FAIL %s sel cycle %0d: got %0d want %0d", nm, c, sel, esel);
                end
            end
            if (c == 1) begin
                checks++;
                if ({best_note, best_score, match} !== {prev_note, prev_score, prev_match}) begin
                    errors++;
                    $display("FAIL %s hold at start: got %0d/%0d/%b want %0d/%0d/%b", nm,
                             best_note, best_score, match, prev_note, prev_score, prev_match);
                end
            end
            if (c == ec || c == ec + tail) begin
                checks++;
                if ({best_note, best_score, match} !== {en, es, em}) begin
                    errors++;
                    $display("FAIL %s result cycle %0d: got %0d/%0d/%b want %0d/%0d/%b", nm, c,
                             best_note, best_score, match, en, es, em);
                end
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        prev_note = en;
        prev_score = es;
        prev_match = em;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({sel, busy, done, best_note, best_score, match} !== '0) begin
            errors++;
            $display("FAIL reset outputs: got sel=%0d busy=%b done=%b note=%0d score=%0d match=%b want all 0",
                     sel, busy, done, best_note, best_score, match);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_note_a();
        run(tmpl[0], 0, 0, 2, "note_a");
    endtask

    task automatic test_note_g();
        run(tmpl[6], 0, 0, 2, "note_g");
    endtask

    task automatic test_zero_window();
        run('0, 0, 0, 2, "zero_window");
    endtask

    task automatic test_random();
        logic [255:0] w;
        for (int i = 0; i < 5; i++) begin
            w = (i == 2) ? tmpl[3] :
                (i % 2 == 0) ? rand256() :
                tmpl[$urandom_range(0, 6)] ^ (rand256() & rand256() & rand256() & rand256());
            run(w, 0, 0, 1, "random");
        end
    endtask

    task automatic test_ignored_start();
        run(tmpl[5] ^ (rand256() & rand256() & rand256()), 5, 113, 4, "ignored_start");
    endtask

    task automatic test_back_to_back();
        run(tmpl[1] ^ (rand256() & rand256() & rand256() & rand256()), 0, 0, 0, "b2b_first");
        run(tmpl[4], 0, 0, 2, "b2b_second");
    endtask

    task automatic test_reset_mid_scan();
        @(negedge clk);
        window = tmpl[2];
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sel, busy, done, best_note, best_score, match} !== '0) begin
            errors++;
            $display("FAIL mid_reset outputs: got sel=%0d busy=%b done=%b note=%0d score=%0d match=%b want all 0",
                     sel, busy, done, best_note, best_score, match);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset done during reset: got %b want 0", done);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        prev_note = '0;
        prev_score = '0;
        prev_match = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset after release: got done=%b busy=%b want 0 0", done, busy);
        end
        run(tmpl[2] ^ (rand256() & rand256() & rand256()), 0, 0, 2, "after_reset");
    endtask

    initial begin
        for (int k = 0; k < 7; k++) tmpl[k] = rand256();
        tmpl[2] = rand256() & rand256() & rand256();
        tmpl[4] = {tmpl[2][127:0], tmpl[2][255:128]};
        tmpl[7] = '0;
        test_reset();
        test_note_a();
        test_note_g();
        test_zero_window();
        test_random();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
